// File: rtl/datapath_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// datapath_pkg: opcodes, FSM states and ALU operations for datapath_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package datapath_pkg;

  localparam logic [6:0] c_op_none  = 7'd0;
  localparam logic [6:0] c_op_li    = 7'd1;
  localparam logic [6:0] c_op_store = 7'd2;
  localparam logic [6:0] c_op_load  = 7'd3;
  localparam logic [6:0] c_op_add   = 7'd4;
  localparam logic [6:0] c_op_sub   = 7'd5;
  localparam logic [6:0] c_op_and   = 7'd6;
  localparam logic [6:0] c_op_or    = 7'd7;
  localparam logic [6:0] c_op_xor   = 7'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'd0,
    ALU_PASS = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// datapath_alu: combinational ALU, logic ops only with DATAPATH_LOGIC_OPS_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  alu_op_t             op,
  output logic [WORDSIZE-1:0] y,
  output logic                zero,
  output logic                ovf
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      ALU_PASS: y = a;
      ALU_ADD: begin
        y   = a + b;
        ovf = (a[WORDSIZE-1] == b[WORDSIZE-1]) && (y[WORDSIZE-1] != a[WORDSIZE-1]);
      end
      ALU_SUB: begin
        y   = a - b;
        ovf = (a[WORDSIZE-1] != b[WORDSIZE-1]) && (y[WORDSIZE-1] != a[WORDSIZE-1]);
      end
`ifdef DATAPATH_LOGIC_OPS_EN
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
`endif
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// datapath_sequencer: 5-state multi-cycle datapath (regfile, data memory, ALU)
// Optional logic ops via DATAPATH_LOGIC_OPS_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int WORDSIZE   = 64,
  parameter int REG_ADDR_W = 5,
  parameter int DM_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            op_code,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [WORDSIZE-1:0]   imm,
  output logic                  busy,
  output logic                  done,
  output logic [WORDSIZE-1:0]   result,
  output logic                  zero,
  output logic                  ovf,
  output logic                  err
);

  localparam int RF_DEPTH = 2 ** REG_ADDR_W;
  localparam int DM_DEPTH = 2 ** DM_ADDR_W;

  state_t                state_q, state_d;
  logic [6:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WORDSIZE-1:0]   imm_q, imm_d, opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

  logic [WORDSIZE-1:0]   rf_q [RF_DEPTH];
  logic [WORDSIZE-1:0]   dm_q [DM_DEPTH];

  alu_op_t               alu_op;
  logic                  legal, wr_rf, wr_dm, rf_we, dm_we;
  logic                  alu_zero, alu_ovf;
  logic [WORDSIZE-1:0]   alu_y, rf_rd1, rf_rd2;
  logic [DM_ADDR_W-1:0]  dm_raddr, dm_waddr;

  always_comb begin
    alu_op = ALU_ZERO;
    legal  = 1'b1;
    wr_rf  = 1'b0;
    wr_dm  = 1'b0;
    case (op_q)
      c_op_none:  ;
      c_op_li:    begin alu_op = ALU_PASS; wr_rf = 1'b1; end
      c_op_store: begin alu_op = ALU_PASS; wr_dm = 1'b1; end
      c_op_load:  begin alu_op = ALU_PASS; wr_rf = 1'b1; end
      c_op_add:   begin alu_op = ALU_ADD;  wr_rf = 1'b1; end
      c_op_sub:   begin alu_op = ALU_SUB;  wr_rf = 1'b1; end
`ifdef DATAPATH_LOGIC_OPS_EN
      c_op_and:   begin alu_op = ALU_AND;  wr_rf = 1'b1; end
      c_op_or:    begin alu_op = ALU_OR;   wr_rf = 1'b1; end
      c_op_xor:   begin alu_op = ALU_XOR;  wr_rf = 1'b1; end
`endif
      default:    legal = 1'b0;
    endcase
  end

  // Register 0 is hard-wired to zero on the read side; writes to it are gated below.
  assign rf_rd1   = (rs1_q == '0) ? '0 : rf_q[rs1_q];
  assign rf_rd2   = (rs2_q == '0) ? '0 : rf_q[rs2_q];
  assign dm_raddr = DM_ADDR_W'(rs1_q);
  assign dm_waddr = DM_ADDR_W'(rd_q);
  assign rf_we    = (state_q == ST_WRITE) && wr_rf && (rd_q != '0);
  assign dm_we    = (state_q == ST_WRITE) && wr_dm;

  datapath_alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .a    (opa_q),
    .b    (opb_q),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_code;
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd;
          imm_d   = imm;
          busy_d  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Operand A doubles as the source for li and load so the ALU just passes it through.
        if (op_q == c_op_li)        opa_d = imm_q;
        else if (op_q == c_op_load) opa_d = dm_q[dm_raddr];
        else                        opa_d = rf_rd1;
        opb_d   = rf_rd2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_y;
        zero_d   = alu_zero;
        ovf_d    = alu_ovf;
        err_d    = !legal;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd_q] <= result_q;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (dm_we) dm_q[dm_waddr] <= result_q;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_datapath_sequencer: directed + random ops against an architectural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  op_code;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic        busy, done, zero, ovf, err;
  logic [63:0] result;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [63:0] m_rf [32];
  logic [63:0] m_dm [32];
  bit          m_dm_ok [32];

  localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;

  datapath_sequencer #(.WORDSIZE(64), .REG_ADDR_W(5), .DM_ADDR_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_code (op_code),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .imm     (imm),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .ovf     (ovf),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation: operands read first, then one write.
  task automatic model_op(input logic [6:0] op, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] d, input logic [63:0] im,
                          output logic [63:0] res, output logic o, output logic e);
    logic [63:0]       va, vb;
    logic signed [64:0] wide;
    bit                wr;
    va  = (a1 == 5'd0) ? 64'd0 : m_rf[a1];
    vb  = (a2 == 5'd0) ? 64'd0 : m_rf[a2];
    res = 64'd0; o = 1'b0; e = 1'b0; wr = 1'b0;
    case (op)
      7'd0: ;
      7'd1: begin res = im; wr = 1'b1; end
      7'd2: begin res = va; m_dm[d] = va; m_dm_ok[d] = 1'b1; end
      7'd3: begin res = m_dm[a1]; wr = 1'b1; end
      7'd4: begin
        wide = $signed({va[63], va}) + $signed({vb[63], vb});
        res = wide[63:0]; o = (wide > SMAX) || (wide < SMIN); wr = 1'b1;
      end
      7'd5: begin
        wide = $signed({va[63], va}) - $signed({vb[63], vb});
        res = wide[63:0]; o = (wide > SMAX) || (wide < SMIN); wr = 1'b1;
      end
`ifdef DATAPATH_LOGIC_OPS_EN
      7'd6: begin res = va & vb; wr = 1'b1; end
      7'd7: begin res = va | vb; wr = 1'b1; end
      7'd8: begin res = va ^ vb; wr = 1'b1; end
`endif
      default: e = 1'b1;
    endcase
    if (wr && d != 5'd0) m_rf[d] = res;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input logic [6:0] op, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input logic [63:0] im);
    logic [63:0] eres;
    logic        eo, ee;
    int          cyc;
    wait_idle();
    start = 1'b1; op_code = op; rs1 = a1; rs2 = a2; rd = d; imm = im;
    @(posedge clk); #1;
    chk($sformatf("op%0d_busy_accept", op), {63'd0, busy}, 64'd1);
    start = 1'b0;
    op_code = 7'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    imm = {$urandom, $urandom};
    model_op(op, a1, a2, d, im, eres, eo, ee);
    cyc = 1;
    while (!done && cyc < 12) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("op%0d_latency", op), 64'(cyc), 64'd4);
    chk($sformatf("op%0d_result", op), result, eres);
    chk($sformatf("op%0d_zero", op), {63'd0, zero}, {63'd0, eres == 64'd0});
    chk($sformatf("op%0d_ovf", op), {63'd0, ovf}, {63'd0, eo});
    chk($sformatf("op%0d_err", op), {63'd0, err}, {63'd0, ee});
  endtask

  initial begin
    int          dn, rises;
    logic        pb;
    logic [63:0] dummy;
    logic        d_o, d_e;

    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_dm[i] = '0; m_dm_ok[i] = 1'b0; end
    rst_n = 1'b0; start = 1'b0; op_code = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(7'd1, 5'd0, 5'd0, 5'd3, 64'h5);
    run_op(7'd1, 5'd0, 5'd0, 5'd4, 64'h7);
    run_op(7'd4, 5'd3, 5'd4, 5'd5, 64'h0);
    run_op(7'd1, 5'd0, 5'd0, 5'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op(7'd1, 5'd0, 5'd0, 5'd2, 64'h1);
    run_op(7'd4, 5'd1, 5'd2, 5'd6, 64'h0);
    run_op(7'd5, 5'd2, 5'd2, 5'd7, 64'h0);
    run_op(7'd5, 5'd6, 5'd2, 5'd6, 64'h0);
    run_op(7'd2, 5'd5, 5'd0, 5'd9, 64'h0);
    run_op(7'd3, 5'd9, 5'd0, 5'd8, 64'h0);
    run_op(7'd1, 5'd0, 5'd0, 5'd0, 64'h55);
    run_op(7'd4, 5'd0, 5'd3, 5'd9, 64'h0);

    // start held high: one accept every 5 cycles, each increments r12 once
    wait_idle();
    start = 1'b1; op_code = 7'd4; rs1 = 5'd12; rs2 = 5'd2; rd = 5'd12; imm = '0;
    dn = 0; rises = 0; pb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (busy && !pb) rises++;
      pb = busy;
      if (i == 16) start = 1'b0;
    end
    for (int i = 0; i < 4; i++) model_op(7'd4, 5'd12, 5'd2, 5'd12, 64'd0, dummy, d_o, d_e);
    chk("held_start_dones", 64'(dn), 64'd4);
    chk("held_start_accepts", 64'(rises), 64'd4);
    run_op(7'd4, 5'd12, 5'd0, 5'd14, 64'h0);

    run_op(7'h7F, 5'd3, 5'd4, 5'd5, 64'h0);
    run_op(7'h7F, 5'd3, 5'd4, 5'd9, 64'h0);
    run_op(7'd4, 5'd5, 5'd0, 5'd9, 64'h0);
    run_op(7'd3, 5'd9, 5'd0, 5'd8, 64'h0);
    run_op(7'd6, 5'd3, 5'd4, 5'd11, 64'h0);
    run_op(7'd4, 5'd11, 5'd0, 5'd13, 64'h0);

    // reset while add r10 is in EXEC
    wait_idle();
    start = 1'b1; op_code = 7'd4; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd10;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    run_op(7'd4, 5'd10, 5'd0, 5'd15, 64'h0);
    run_op(7'd4, 5'd3, 5'd4, 5'd15, 64'h0);
    run_op(7'd3, 5'd9, 5'd0, 5'd16, 64'h0);

    for (int k = 0; k < 40; k++) begin
      logic [6:0] rop;
      logic [4:0] ra, rb, rdd;
      int         sel;
      sel = $urandom_range(0, 11);
      if (sel <= 8) rop = 7'(sel);
      else if (sel <= 10) rop = 7'd1;
      else rop = 7'($urandom_range(9, 127));
      ra = 5'($urandom); rb = 5'($urandom); rdd = 5'($urandom);
      if (k % 7 == 0) begin rb = ra; rdd = ra; end
      if (rop == 7'd3 && !m_dm_ok[DM_IDX(ra)]) rop = 7'd2;
      run_op(rop, ra, rb, rdd, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  function automatic int DM_IDX(input logic [4:0] r);
    return int'(r);
  endfunction

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
# datapath_sequencer

Parametrised multi-cycle datapath for the SDII processor: owns a register file, a data memory and an ALU, and executes one operation per start/done handshake. Supported operations are load-immediate, load, store, add, sub and optional bitwise logic, all with a fixed latency. Sits between the instruction-decode stage and the memory subsystem. Replaces the single-op, resetless add datapath with a resettable, handshaked, width-generic block that reports flags and errors.

## Interface
- WORDSIZE, 64, datapath word width in bits (≥ 8)
- REG_ADDR_W, 5, register index width; register file holds 2^REG_ADDR_W words
- DM_ADDR_W, 5, data-memory index width; memory holds 2^DM_ADDR_W words
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- op_code  in  7  operation to execute
- rs1, rs2, rd  in  REG_ADDR_W each  operand and destination indices
- imm  in  WORDSIZE  immediate for load-immediate
- busy  out  1  high from the accept edge until DONE is left
- done  out  1  one-cycle pulse when the operation has committed
- result  out  WORDSIZE  value written or stored, valid while done = 1
- zero  out  1  result == 0, valid with done
- ovf  out  1  signed overflow (add/sub only), valid with done
- err  out  1  illegal op_code, valid with done

## Operation
- Opcodes:
  - 0 = none
  - 1 = li: rf[rd] ← imm
  - 2 = store: dm[rd] ← rf[rs1]
  - 3 = load: rf[rd] ← dm[rs1]
  - 4 = add: rf[rd] ← rf[rs1] + rf[rs2]
  - 5 = sub: rf[rd] ← rf[rs1] − rf[rs2]
  - 6 = and, 7 = or, 8 = xor: rf[rd] ← rf[rs1] op rf[rs2]
  - All other codes are illegal.
- Memory addressing: data-memory index = register field truncated or zero-extended to DM_ADDR_W.
- Register 0 always reads 0. Writes to register 0 are discarded, but result and flags are still reported.
- FSM states: IDLE → READ → EXEC → WRITE → DONE → IDLE.
  - IDLE: start = 1 latches op_code, rs1, rs2, rd and imm.
  - READ: latches register operands and issues the synchronous data-memory read.
  - EXEC: registers the ALU output or load data into result_q.
  - WRITE: commits the single register-file or data-memory write.
  - DONE: drives done = 1.
- none and illegal ops traverse the same states with no write. Their result is 0; err = 1 for illegal codes only.
- Arithmetic:
  - Two's complement, modulo 2^WORDSIZE.
  - ovf = operand signs equal (add) or different (sub) and result sign differs from operand a.
  - ovf = 0 for every non-arithmetic op.
- Reset:
  - FSM returns to IDLE.
  - All outputs go to 0.
  - Register file is cleared to 0.
  - Data memory is not cleared.
  - Reset during any state aborts the operation; no write occurs if reset precedes the WRITE edge.

## Timing
- The accept edge is E0. READ, EXEC, WRITE and DONE occupy the cycles after E0, E1, E2 and E3.
- done is high in the cycle after E3: fixed latency of 4 cycles.
- The next accept can occur at E5 at the earliest, giving a throughput of one op per 5 cycles.
- start while busy is ignored, not queued. Inputs other than start are don't-care after E0.
- Read-after-write across back-to-back ops returns the new value, because the write commits at E3, before the next READ.
- A store followed by a load of the same address returns the stored word.
- rs1 == rs2 == rd is legal; operands are read before the write.

## Configuration
- DATAPATH_LOGIC_OPS_EN defined: opcodes 6–8 are legal and the ALU implements and/or/xor.
- Not defined: opcodes 6–8 are illegal (err = 1, no write) and the logic gates are not synthesised.

## Structure
- Shared package datapath_pkg holds:
  - opcode localparams
  - FSM state encoding
  - the ALU-op enumeration
- One sub-module, datapath_alu: combinational, WORDSIZE-parametrised; outputs y, zero and ovf.
- The register file and data memory are internal arrays within datapath_sequencer.

## Test plan
- Reset then li r3 ← 0x5, li r4 ← 0x7, add r5 ← r3 + r4 → each done 4 cycles after accept; result = 0xC, zero = 0, ovf = 0.
- li r1 ← 0x7FFF_FFFF_FFFF_FFFF, li r2 ← 1, add r6 → result = 0x8000_0000_0000_0000, ovf = 1. Then sub r7 ← r2 − r2 → result = 0, zero = 1.
- store dm[9] ← r5, then load r8 ← dm[9] → load result = 0xC. Then li r0 ← 0x55 → result = 0x55 but a later add with r0 reads 0.
- start held high continuously → accepts only at 5-cycle spacing; no duplicate writes.
- op_code 0x7F → done with err = 1, result = 0, and no register or memory change. op 6 → err depends on DATAPATH_LOGIC_OPS_EN (logic result when defined).
- Assert rst_n low during EXEC of add r10 → busy and done drop; r10 remains 0 after reset.
